ps2_scan_rx: RTL and testbench
==============================

# ps2_scan_rx

Parametrised PS/2 keyboard receiver that replaces the fixed 8-entry receiver in the keyboard path. It synchronises and glitch-filters the PS/2 lines, frames and validates 11-bit packets, and folds `E0`/`F0` prefixes into a tagged key event. Events go into a FIFO of configurable depth that the display/VGA logic drains. It adds error reporting, a frame timeout and a fill level.

## Interface
- `FIFO_DEPTH`, 8: number of event entries; must be a power of 2 and ≥ 2.
- `FILTER_LEN`, 4: consecutive equal samples required before the filtered `ps2_clk` changes; range 1–15.
- `TIMEOUT`, 5000: number of `clk` cycles without a sample strobe, mid-frame, before the frame is aborted.
- `clk` input 1: system clock. One clock domain.
- `clr` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock from the keyboard.
- `ps2_data` input 1: raw PS/2 data from the keyboard.
- `nextdata_n` input 1: active-low pop request; sampled on `clk`.
- `data` output 10: head event `{ext, brk, code[7:0]}`.
- `ready` output 1: FIFO not empty.
- `level` output $clog2(FIFO_DEPTH)+1: number of stored events.
- `overflow` output 1: sticky; an event was dropped because the FIFO was full.
- `parity_err` output 1: sticky; a frame had a bad start bit, stop bit or parity.
- `timeout_err` output 1: sticky; a frame was aborted by timeout.

## Operation
- **Reset values.** While `clr` is high, all of these are 0: pointers, `level`, `ready`, the three sticky flags, the bit counter, the prefix flags and the timeout counter. Synchroniser and filter state reset to 1, the idle line level. `data` is don't-care while `ready` = 0.
- **Input conditioning.**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - The filtered clock takes the synchronised value once that value has been stable for `FILTER_LEN` consecutive cycles.
  - The sample strobe is a one-cycle pulse on a 1→0 transition of the filtered clock.
  - Data is taken from the synchronised `ps2_data` in the strobe cycle.
- **Frame FSM.** States are IDLE and SHIFT, with a 4-bit counter.
  - IDLE → SHIFT on a strobe; this bit is stored as bit 0.
  - In SHIFT, each strobe stores bit n. On bit 10 the FSM returns to IDLE and validates the frame.
  - A frame is valid when bit0 = 0, bit10 = 1 and bits 1–9 have odd parity.
  - An invalid frame is dropped, sets `parity_err`, and clears both prefix flags.
- **Timeout.** The timeout counter clears on every strobe and counts only in SHIFT. When it reaches `TIMEOUT`:
  - the FSM returns to IDLE and the partial bits are discarded;
  - `timeout_err` is set;
  - both prefix flags are cleared.
- **Prefix decode** for a valid byte `b`:
  - `b` = `E0`: set `ext`; nothing is pushed.
  - `b` = `F0`: set `brk`; nothing is pushed.
  - Any other `b`: push `{ext, brk, b}`, then clear both flags.
- **FIFO.**
  - Push happens in the cycle after validation. If the FIFO is full and no pop occurs in that cycle, the new event is dropped and `overflow` is set; stored entries are never overwritten.
  - Pop happens when `ready` = 1 and `nextdata_n` = 0. Each cycle this holds pops one entry.
  - A pop with `ready` = 0 is ignored.
  - Simultaneous push and pop on a full FIFO: both are performed, `level` stays at `FIFO_DEPTH`, and `overflow` is not set.
  - Pointers wrap modulo `FIFO_DEPTH`. `level` counts 0..`FIFO_DEPTH`.
- **Outputs.**
  - `data` = `fifo[r_ptr]`, combinational from registers.
  - `ready` = (`level` != 0).
  - Sticky flags clear only through `clr`.

## Timing
- Raw `ps2_clk` falling edge to strobe: 2 + `FILTER_LEN` + 1 cycles, exact when the input is clean.
- Strobe of the stop bit to `ready`/`level`/`data` update: 1 cycle, i.e. on the next rising edge of `clk`.
- A pop sampled at rising edge N gives the new `data`/`level` after edge N. Back-to-back pops are allowed, one per cycle.
- Flags assert on the same edge as the corresponding FSM action (drop, abort or rejected push).
- `clr` asserted mid-frame or mid-pop clears state asynchronously. The first frame whose start bit arrives after `clr` deasserts is received normally.
- A `ps2_clk` glitch shorter than `FILTER_LEN` cycles produces no strobe.

## Test plan
- Reset, then send a clean frame of `1C` (PS/2 clock about 12 kHz) → `data` = `0x01C`, `ready` = 1, `level` = 1. Pulse `nextdata_n` low for one cycle → `ready` = 0, `level` = 0.
- Send `E0`, `F0`, `74` → exactly one event, `data` = `0x374`. A following `1C` → `0x01C`, showing the prefix flags were cleared.
- Send a frame with wrong parity, then a valid `F0` followed by a frame with a bad stop bit, then `29` → `parity_err` = 1, only `0x029` is stored, and `brk` is clear.
- With `FIFO_DEPTH` = 8, send 9 codes `01`..`09` without popping → `level` = 8, `overflow` = 1, `data` = `0x001`. Draining gives `01`..`08`. Repeat full + push with a concurrent pop → `overflow` stays as it was before the repeat (check that it does not newly set after a fresh reset).
- Send 5 bits, then hold the lines idle for `TIMEOUT` + 10 cycles → `timeout_err` = 1 and nothing is pushed. The next full frame `5A` → `0x05A`.
- Inject a 2-cycle low glitch on `ps2_clk` with `FILTER_LEN` = 4 mid-frame → no extra bit, correct code received. Assert `clr` mid-frame → all outputs 0 immediately, and the next frame is received correctly.

Source files
------------

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronise and glitch-filter the PS/2 lines, frame 11-bit packets,
// fold E0/F0 prefixes into tagged events and queue them in a FIFO for the display logic.
module ps2_scan_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 5000
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          nextdata_n,
  output logic [9:0]                    data,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    FL_M1 = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] FULL  = LW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [1:0]    r_clk_s, r_dat_s;
  logic          r_fclk, r_fclk_d;
  logic [3:0]    r_fcnt;
  state_t        r_state, w_next;
  logic [3:0]    r_bitcnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_tcnt;
  logic          r_ext, r_brk, r_perr, r_terr, r_ovf;
  logic          r_push;
  logic [9:0]    r_push_data;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic [9:0]    r_mem [FIFO_DEPTH];

  logic          w_strobe, w_bit, w_done, w_tout, w_valid;
  logic [10:0]   w_frame;
  logic [7:0]    w_byte;
  logic          w_pop, w_full, w_wr;

  // The filtered clock only follows the synchronised line after FILTER_LEN equal samples.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_clk_s  <= 2'b11;
      r_dat_s  <= 2'b11;
      r_fclk   <= 1'b1;
      r_fclk_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s  <= {r_clk_s[0], ps2_clk};
      r_dat_s  <= {r_dat_s[0], ps2_data};
      r_fclk_d <= r_fclk;
      if (r_clk_s[1] == r_fclk) r_fcnt <= '0;
      else if (r_fcnt == FL_M1) begin
        r_fclk <= r_clk_s[1];
        r_fcnt <= '0;
      end else r_fcnt <= r_fcnt + 4'd1;
    end
  end

  assign w_strobe = r_fclk_d & ~r_fclk;
  assign w_bit    = r_dat_s[1];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_strobe) w_next = S_SHIFT;
      S_SHIFT: if (w_done || w_tout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_done  = (r_state == S_SHIFT) && w_strobe && (r_bitcnt == 4'd10);
    w_tout  = (r_state == S_SHIFT) && !w_strobe && (r_tcnt == TO_M1);
    w_frame = {w_bit, r_shift};
    w_valid = !w_frame[0] && w_frame[10] && (^w_frame[9:1]);
    w_byte  = w_frame[8:1];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_tcnt      <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_perr      <= 1'b0;
      r_terr      <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_strobe || r_state != S_SHIFT || w_tout) r_tcnt <= '0;
      else                                          r_tcnt <= r_tcnt + TW'(1);
      if (w_done || w_tout) r_bitcnt <= '0;
      else if (w_strobe)    r_bitcnt <= r_bitcnt + 4'd1;
      if (w_strobe && !w_done) r_shift[r_bitcnt] <= w_bit;
      if (w_tout) begin
        r_terr <= 1'b1;
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
      end
      if (w_done) begin
        if (!w_valid) begin
          r_perr <= 1'b1;
          r_ext  <= 1'b0;
          r_brk  <= 1'b0;
        end else if (w_byte == 8'hE0) r_ext <= 1'b1;
        else if (w_byte == 8'hF0)     r_brk <= 1'b1;
        else begin
          r_push      <= 1'b1;
          r_push_data <= {r_ext, r_brk, w_byte};
          r_ext       <= 1'b0;
          r_brk       <= 1'b0;
        end
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_pop  = ready & ~nextdata_n;
  assign w_full = (r_level == FULL);
  assign w_wr   = r_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_wr) - LW'(w_pop);
      if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_push_data;
  end

  assign data        = r_mem[r_rptr];
  assign ready       = (r_level != '0);
  assign level       = r_level;
  assign overflow    = r_ovf;
  assign parity_err  = r_perr;
  assign timeout_err = r_terr;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: drives PS/2 frames (directed and random) and compares against a
// frame-level queue model of prefix folding, FIFO occupancy and sticky error flags.
module tb_ps2_scan_rx;
  localparam int DEPTH = 8;
  localparam int FL    = 4;
  localparam int TO    = 200;
  localparam int H     = 30;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [9:0] data;
  logic       ready;
  logic [3:0] level;
  logic       overflow, parity_err, timeout_err;

  ps2_scan_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .data(data), .ready(ready), .level(level), .overflow(overflow),
    .parity_err(parity_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [9:0] mq[$];
  bit m_ext, m_brk, m_ovf, m_perr, m_terr;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(logic [7:0] b, bit bad_par, bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  function automatic void model_frame(logic [7:0] b, bit ok, bit cpop);
    if (cpop && mq.size() > 0) void'(mq.pop_front());
    if (!ok) begin
      m_perr = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0; m_terr = 0;
  endfunction

  // nbits < 11 leaves a partial frame; cpop pops during the push cycle of the stop bit.
  task automatic send_bits(logic [10:0] f, int nbits, bit cpop, int glitch_bit);
    cyc(1);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(H / 2);
      ps2_clk = 1'b0;
      if (cpop && i == 10) begin
        cyc(3 + FL);
        nextdata_n = 1'b0;
        cyc(1);
        nextdata_n = 1'b1;
        cyc(H - 4 - FL);
      end else cyc(H);
      ps2_clk = 1'b1;
      if (i == glitch_bit) begin
        cyc(H / 4);
        ps2_clk = 1'b0;
        cyc(2);
        ps2_clk = 1'b1;
        cyc(H / 2 - H / 4 - 2);
      end else cyc(H / 2);
    end
    ps2_data = 1'b1;
    cyc(H);
  endtask

  task automatic send(logic [7:0] b, bit bad_par = 0, bit bad_stop = 0, bit cpop = 0,
                      int glitch_bit = -1);
    send_bits(mk_frame(b, bad_par, bad_stop), 11, cpop, glitch_bit);
    model_frame(b, !(bad_par || bad_stop), cpop);
  endtask

  task automatic pop();
    nextdata_n = 1'b0;
    cyc(1);
    nextdata_n = 1'b1;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic check_all(string tag);
    @(negedge clk);
    chk({tag, ":level"}, level, mq.size());
    chk({tag, ":ready"}, ready, mq.size() != 0);
    if (mq.size() > 0) chk({tag, ":data"}, data, mq[0]);
    chk({tag, ":ovf"}, overflow, m_ovf);
    chk({tag, ":perr"}, parity_err, m_perr);
    chk({tag, ":terr"}, timeout_err, m_terr);
    cyc(1);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    cyc(2);
    clr = 1'b0;
    model_reset();
    cyc(2);
  endtask

  initial begin
    model_reset();
    cyc(5);
    check_all("reset");
    clr = 1'b0;
    cyc(2);

    send(8'h1C);
    chk("t1_data", data, 10'h01C);
    check_all("t1");
    pop();
    check_all("t1_pop");

    send(8'hE0); send(8'hF0); send(8'h74);
    chk("t2_data", data, 10'h374);
    check_all("t2");
    pop();
    send(8'h1C);
    chk("t2_clear", data, 10'h01C);
    check_all("t2b");
    pop();

    send(8'h33, 1, 0);
    send(8'hF0);
    send(8'h44, 0, 1);
    send(8'h29);
    chk("t3_data", data, 10'h029);
    chk("t3_perr", parity_err, 1);
    check_all("t3");
    pop();

    do_reset();
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("t4_lvl", level, 8);
    chk("t4_ovf", overflow, 1);
    check_all("t4_full");
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_drain", data, i + 1);
      pop();
      check_all("t4_pop");
    end
    pop();
    check_all("t4_empty_pop");

    do_reset();
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'h09, 0, 0, 1);
    chk("t4b_ovf", overflow, 0);
    chk("t4b_lvl", level, 8);
    chk("t4b_data", data, 10'h002);
    check_all("t4b");

    do_reset();
    send_bits(mk_frame(8'h5A, 0, 0), 5, 0, -1);
    cyc(TO + 10);
    m_terr = 1; m_ext = 0; m_brk = 0;
    chk("t5_terr", timeout_err, 1);
    check_all("t5_to");
    send(8'h5A);
    chk("t5_data", data, 10'h05A);
    check_all("t5");
    pop();

    send(8'h3B, 0, 0, 0, 4);
    chk("t6_glitch", data, 10'h03B);
    check_all("t6");
    pop();

    for (int n = 0; n < 24; n++) begin
      int kind;
      logic [7:0] b;
      kind = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (kind == 1) b = 8'hE0;
      if (kind == 2) b = 8'hF0;
      if ($urandom_range(0, 2) == 0) pop();
      send(b, kind == 0, 0);
      check_all("rand");
    end

    send(8'h77);
    send_bits(mk_frame(8'h12, 0, 0), 4, 0, -1);
    clr = 1'b1;
    #2;
    chk("t7_level", level, 0);
    chk("t7_ready", ready, 0);
    chk("t7_ovf", overflow, 0);
    chk("t7_perr", parity_err, 0);
    chk("t7_terr", timeout_err, 0);
    cyc(2);
    clr = 1'b0;
    model_reset();
    cyc(2);
    send(8'h66);
    chk("t7_data", data, 10'h066);
    check_all("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
